max_arbiter: RTL and testbench
==============================

# max_arbiter

Frame-level round-robin arbiter that shares one pipelined max datapath between NUM_REQ requesters. Grants one requester for a whole frame of FRAME_LEN words, streams the words into the datapath under valid/ready, and marks the final word. Tags each frame with its requester ID in an in-order tag FIFO, then returns each datapath result with that ID. Sits between client ports and the max pipeline; it does no arithmetic on data.

## Interface
- DATA_WIDTH, 8, width of every data word and result
- NUM_REQ, 4, number of requesters (2..8)
- FRAME_LEN, 4, words per frame (≥1); one result per frame
- TAG_DEPTH, 4, maximum frames in flight (tag FIFO depth, power of 2)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous, active-high reset
- req_val  input  NUM_REQ  per-requester word valid
- req_data  input  NUM_REQ*DATA_WIDTH  flat packed words, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_rdy  output  NUM_REQ  per-requester word accepted
- dp_val  output  1  word valid to datapath
- dp_data  output  DATA_WIDTH  word to datapath
- dp_last  output  1  qualifies dp_val: last word of frame
- dp_rdy  input  1  datapath can accept a word
- dp_res_val  input  1  datapath result valid
- dp_res_data  input  DATA_WIDTH  datapath result (frame max)
- dp_res_rdy  output  1  result consumed
- res_val  output  1  tagged result valid
- res_data  output  DATA_WIDTH  result value
- res_id  output  clog2(NUM_REQ)  requester that owns the result
- res_rdy  input  1  downstream consumes result
- busy  output  1  frame streaming or frames in flight
- err  output  1  sticky: result arrived with no tag outstanding

## Operation
- FSM states: IDLE, STREAM.
- IDLE: if any req_val[i] high and tag count < TAG_DEPTH, pick the winner by round-robin. Priority starts at rr_ptr and wraps upward. Register grant_id ← winner, push the winner into the tag FIFO, clear the word counter, and go to STREAM. If the tag FIFO is full, stay in IDLE and hold all req_rdy low.
- STREAM:
  - dp_val = req_val[grant_id]; dp_data = the granted slice.
  - req_rdy[grant_id] = dp_rdy; all other req_rdy bits are 0.
  - A transfer is a cycle with dp_val && dp_rdy; each transfer increments the word counter.
  - dp_last = dp_val && (word counter == FRAME_LEN-1).
  - On the transfer with dp_last, set rr_ptr ← (grant_id+1) mod NUM_REQ and return to IDLE.
  - Deasserting req_val mid-frame only stalls; the grant is held until FRAME_LEN words have transferred.
- In IDLE: dp_val = 0, dp_last = 0, req_rdy = 0.
- Result path (combinational, any state):
  - res_val = dp_res_val && tag FIFO non-empty.
  - res_id = FIFO head; res_data = dp_res_data.
  - dp_res_rdy = res_rdy when the FIFO is non-empty, else 1.
  - Pop the FIFO on res_val && res_rdy.
- Spurious result (dp_res_val while the FIFO is empty): consume it (dp_res_rdy = 1), set err = 1, and leave res_val low. err holds until reset.
- Push and pop in the same cycle: tag count unchanged. A push is never attempted when full.
- busy = (state == STREAM) || tag count != 0.
- rr_ptr and the word counter wrap modulo NUM_REQ and FRAME_LEN respectively.

## Timing
- Reset, applied at any time (including mid-frame or with tags outstanding), does the following at the next edge:
  - state = IDLE, rr_ptr = 0, grant_id = 0, word counter = 0, tag FIFO emptied, err = 0.
  - Outputs: req_rdy = 0, dp_val = 0, dp_last = 0, res_val = 0, busy = 0.
  - Partially sent frames are abandoned; the datapath is reset by the same rst_n.
- Arbitration latency: request seen in IDLE at cycle n → grant registered at edge n+1 → first word can transfer in cycle n+1.
- Minimum frame occupancy is FRAME_LEN cycles in STREAM plus 1 IDLE cycle. Back-to-back frames therefore have a 1-cycle bubble.
- Datapath result latency is not assumed; ordering is. The datapath returns results in frame order.
- Result path adds zero cycles of latency.

## Test plan
- Single requester: req 2 sends frame 5,9,3,7 with dp_rdy = 1; datapath returns 9.
  - Required: grant_id = 2; dp_last only on word 7; res_val with res_id = 2, res_data = 9; busy drops after the pop.
- Round-robin: reqs 0, 1 and 3 valid continuously from reset.
  - Required: frames granted in order 0, 1, 3, 0, 1, 3; exactly one IDLE cycle between frames.
  - Required: req_rdy is never high for a non-granted requester.
- Backpressure: dp_rdy toggles 1,0,1,0 during a frame, and req_val drops for 2 cycles.
  - Required: exactly FRAME_LEN transfers; word counter holds during stalls; grant unchanged until dp_last.
- Tag full with stalled results:
  - Setup: TAG_DEPTH = 4, res_rdy = 0 and dp_res_val = 1 stalled, 5 frames requested.
  - Required: 4 frames start, then IDLE holds with req_rdy = 0.
  - Required: raising res_rdy for one cycle pops ID 0, and the 5th frame is granted on the next edge.
- Spurious result: dp_res_val pulses with the FIFO empty.
  - Required: res_val = 0, dp_res_rdy = 1, err = 1 stays set.
- Reset mid-frame: assert rst_n after 2 of 4 words with 1 tag outstanding.
  - Required: next edge gives all outputs at reset values; a new request from req 0 wins first.

Source files
------------

// File: rtl/max_arbiter.sv
// Frame-level round-robin arbiter in front of a shared max pipeline.
// Each granted frame is tagged in an in-order FIFO so results return with their owner ID.
module max_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int FRAME_LEN  = 4,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_val,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic                          dp_val,
  output logic [DATA_WIDTH-1:0]         dp_data,
  output logic                          dp_last,
  input  logic                          dp_rdy,
  input  logic                          dp_res_val,
  input  logic [DATA_WIDTH-1:0]         dp_res_data,
  output logic                          dp_res_rdy,
  output logic                          res_val,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic [$clog2(NUM_REQ)-1:0]    res_id,
  input  logic                          res_rdy,
  output logic                          busy,
  output logic                          err
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int TCNT_W = $clog2(TAG_DEPTH + 1);

  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(FRAME_LEN - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(TAG_DEPTH - 1);
  localparam logic [TCNT_W-1:0] FULL_CNT  = TCNT_W'(TAG_DEPTH);

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [ID_W-1:0]    tag_mem_q [TAG_DEPTH];
  logic [ID_W-1:0]    tag_mem_d [TAG_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TCNT_W-1:0]  tag_cnt_q, tag_cnt_d;
  logic               err_q, err_d;

  logic               any_req;
  logic [ID_W-1:0]    winner;
  logic               tag_empty;
  logic               tag_full;
  logic               push;
  logic               pop;
  logic               xfer;

  assign tag_empty = (tag_cnt_q == '0);
  assign tag_full  = (tag_cnt_q == FULL_CNT);

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] cand;
    any_req = 1'b0;
    winner  = '0;
    idx     = 0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx  = (32'(rr_ptr_q) + k) % NUM_REQ;
      cand = ID_W'(idx);
      if (!any_req && req_val[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  always_comb begin
    dp_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == grant_q) begin
        dp_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    dp_val  = 1'b0;
    dp_last = 1'b0;
    if (state_q == STREAM) begin
      dp_val           = req_val[grant_q];
      req_rdy[grant_q] = dp_rdy;
      dp_last          = req_val[grant_q] && (word_cnt_q == LAST_WORD);
    end
  end

  assign xfer = dp_val && dp_rdy;

  // Results with no tag outstanding are swallowed so the datapath never wedges.
  assign res_val    = dp_res_val && !tag_empty;
  assign res_data   = dp_res_data;
  assign res_id     = tag_mem_q[rd_ptr_q];
  assign dp_res_rdy = tag_empty ? 1'b1 : res_rdy;
  assign pop        = res_val && res_rdy;
  assign busy       = (state_q == STREAM) || !tag_empty;
  assign err        = err_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    word_cnt_d = word_cnt_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req && !tag_full) begin
          grant_d    = winner;
          push       = 1'b1;
          word_cnt_d = '0;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (dp_last) begin
            word_cnt_d = '0;
            rr_ptr_d   = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
            state_d    = IDLE;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_cnt_d = tag_cnt_q;
    if (push) begin
      tag_mem_d[wr_ptr_q] = grant_d;
      wr_ptr_d            = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
      2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
      default: tag_cnt_d = tag_cnt_q;
    endcase
    err_d = err_q || (dp_res_val && tag_empty);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      word_cnt_q <= '0;
      tag_mem_q  <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      word_cnt_q <= word_cnt_d;
      tag_mem_q  <= tag_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_cnt_q  <= tag_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_max_arbiter.sv
// Scoreboard bench for max_arbiter: directed frames, queued expectations, negedge monitor.
module tb_max_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int FL = 4;
  localparam int TD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_val;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_rdy;
  logic            dp_val, dp_last, dp_rdy;
  logic [DW-1:0]   dp_data;
  logic            dp_res_val, dp_res_rdy;
  logic [DW-1:0]   dp_res_data;
  logic            res_val, res_rdy, busy, err;
  logic [DW-1:0]   res_data;
  logic [1:0]      res_id;

  always #5 clk = ~clk;

  max_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .FRAME_LEN(FL), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst),
    .req_val(req_val), .req_data(req_data), .req_rdy(req_rdy),
    .dp_val(dp_val), .dp_data(dp_data), .dp_last(dp_last), .dp_rdy(dp_rdy),
    .dp_res_val(dp_res_val), .dp_res_data(dp_res_data), .dp_res_rdy(dp_res_rdy),
    .res_val(res_val), .res_data(res_data), .res_id(res_id), .res_rdy(res_rdy),
    .busy(busy), .err(err)
  );

  typedef struct packed { logic [1:0] id; logic [7:0] data; logic last; } dp_exp_t;
  typedef struct packed { logic [1:0] id; logic [7:0] data; } res_exp_t;
  dp_exp_t  exp_dp[$];
  res_exp_t exp_res[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester model: per-port word buffers, popped on req_val && req_rdy.
  logic [7:0]    wmem [NR][64];
  logic [5:0]    head [NR];
  logic [5:0]    tail [NR];
  logic [NR-1:0] en;
  logic          flush;

  always_comb begin
    req_val  = '0;
    req_data = '0;
    for (int i = 0; i < NR; i++) begin
      req_val[i]          = en[i] && (head[i] != tail[i]);
      req_data[i*DW +: DW] = wmem[i][head[i]];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (flush) head[i] <= tail[i];
      else if (req_val[i] && req_rdy[i]) head[i] <= head[i] + 6'd1;
    end
  end

  // Datapath stand-in: frame max returned one cycle after the last word, in order.
  logic [7:0] acc;
  logic [7:0] dpq[$];
  logic       auto_val, dp_auto, man_val;
  logic [7:0] auto_data, man_data;

  always @(posedge clk) begin
    if (rst) begin
      acc = 8'd0;
      dpq.delete();
    end else begin
      if (dp_auto && auto_val && dp_res_rdy && dpq.size() != 0) void'(dpq.pop_front());
      if (dp_val && dp_rdy) begin
        if (dp_data > acc) acc = dp_data;
        if (dp_last) begin
          dpq.push_back(acc);
          acc = 8'd0;
        end
      end
    end
    auto_val  <= (dpq.size() != 0);
    auto_data <= (dpq.size() != 0) ? dpq[0] : 8'd0;
  end

  always_comb begin
    dp_res_val  = dp_auto ? auto_val  : man_val;
    dp_res_data = dp_auto ? auto_data : man_data;
  end

  // Monitor
  int   xfer_cnt = 0;
  logic prev_last = 1'b0;
  logic prev_bubble = 1'b0;
  logic rr_phase = 1'b0;

  always @(negedge clk) begin : mon
    dp_exp_t  e;
    res_exp_t r;
    logic [1:0] gid;
    logic pending;
    logic new_bubble;
    pending = (exp_dp.size() != 0);
    if (req_rdy != '0) chk("rdy_onehot", 32'($onehot(req_rdy)), 32'd1);
    if (dp_val && dp_rdy) begin
      xfer_cnt++;
      gid = 2'd0;
      for (int i = 0; i < NR; i++) if (req_rdy[i]) gid = 2'(i);
      if (exp_dp.size() == 0) begin
        chk("dp_unexpected", 32'(dp_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_dp.pop_front();
        chk("dp_id", 32'(gid), 32'(e.id));
        chk("dp_data", 32'(dp_data), 32'(e.data));
        chk("dp_last", 32'(dp_last), 32'(e.last));
      end
    end
    if (res_val && res_rdy) begin
      if (exp_res.size() == 0) begin
        chk("res_unexpected", 32'(res_data), 32'hFFFF_FFFF);
      end else begin
        r = exp_res.pop_front();
        chk("res_id", 32'(res_id), 32'(r.id));
        chk("res_data", 32'(res_data), 32'(r.data));
      end
    end
    if (rr_phase && prev_last) chk("rr_bubble", 32'(dp_val), 32'd0);
    if (rr_phase && prev_bubble && pending) chk("rr_resume", 32'(dp_val), 32'd1);
    new_bubble  = rr_phase && prev_last;
    prev_last   = dp_val && dp_rdy && dp_last;
    prev_bubble = new_bubble;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int id, input logic [7:0] w0, input logic [7:0] w1,
                      input logic [7:0] w2, input logic [7:0] w3, input int n);
    logic [7:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int k = 0; k < n; k++) begin
      wmem[id][tail[id]] = w[k];
      tail[id] = tail[id] + 6'd1;
      exp_dp.push_back('{id: 2'(id), data: w[k], last: (k == FL - 1)});
    end
  endtask

  task automatic exp_result(input int id, input logic [7:0] d);
    exp_res.push_back('{id: 2'(id), data: d});
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n = 0;
    while (xfer_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk("wait_xfers", 32'(xfer_cnt >= target), 32'd1);
  endtask

  task automatic wait_res(input int budget);
    int n = 0;
    while (exp_res.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_res", 32'(exp_res.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b1; en = '0; dp_rdy = 1'b0; res_rdy = 1'b0;
    man_val = 1'b0; dp_auto = 1'b0;
    tick();
    rst = 1'b0; flush = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    @(negedge clk);
    chk({tag, "_req_rdy"}, 32'(req_rdy), 32'd0);
    chk({tag, "_dp_val"}, 32'(dp_val), 32'd0);
    chk({tag, "_dp_last"}, 32'(dp_last), 32'd0);
    chk({tag, "_res_val"}, 32'(res_val), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; flush = 1'b1; en = '0; dp_rdy = 1'b0; res_rdy = 1'b0;
    man_val = 1'b0; man_data = '0; dp_auto = 1'b0;
    for (int i = 0; i < NR; i++) tail[i] = '0;
    tick(); tick();
    check_reset_outs("por");
    do_reset();

    // Single requester 2: 5,9,3,7 -> max 9
    base = xfer_cnt;
    load(2, 8'd5, 8'd9, 8'd3, 8'd7, 4);
    en = 4'b0100; dp_rdy = 1'b1;
    wait_xfers(base + 4, 20);
    @(negedge clk);
    chk("single_busy_tag", 32'(busy), 32'd1);
    chk("single_res_idle", 32'(res_val), 32'd0);
    tick();
    man_val = 1'b1; man_data = 8'd9; res_rdy = 1'b1;
    exp_result(2, 8'd9);
    tick();
    man_val = 1'b0; res_rdy = 1'b0;
    @(negedge clk);
    chk("single_busy_drop", 32'(busy), 32'd0);
    chk("single_drained", 32'(exp_res.size()), 32'd0);

    // Spurious result with empty tag FIFO
    do_reset();
    man_val = 1'b1; man_data = 8'hAA;
    @(negedge clk);
    chk("spur_res_val", 32'(res_val), 32'd0);
    chk("spur_dp_res_rdy", 32'(dp_res_rdy), 32'd1);
    chk("spur_err_before", 32'(err), 32'd0);
    tick();
    man_val = 1'b0;
    @(negedge clk);
    chk("spur_err_set", 32'(err), 32'd1);
    tick(); tick(); tick();
    @(negedge clk);
    chk("spur_err_sticky", 32'(err), 32'd1);
    do_reset();
    @(negedge clk);
    chk("spur_err_cleared", 32'(err), 32'd0);

    // Round-robin among 0,1,3: grant order 0,1,3,0,1,3
    do_reset();
    base = xfer_cnt;
    load(0, 8'd10, 8'd40, 8'd20, 8'd30, 4); exp_result(0, 8'd40);
    load(1, 8'd55, 8'd11, 8'd66, 8'd22, 4); exp_result(1, 8'd66);
    load(3, 8'd7,  8'd3,  8'd9,  8'd1,  4); exp_result(3, 8'd9);
    load(0, 8'd80, 8'd81, 8'd82, 8'd83, 4); exp_result(0, 8'd83);
    load(1, 8'd2,  8'd1,  8'd4,  8'd3,  4); exp_result(1, 8'd4);
    load(3, 8'd99, 8'd98, 8'd97, 8'd96, 4); exp_result(3, 8'd99);
    en = 4'b1011; dp_rdy = 1'b1; res_rdy = 1'b1; dp_auto = 1'b1; rr_phase = 1'b1;
    wait_xfers(base + 24, 80);
    tick();
    rr_phase = 1'b0;
    wait_res(20);

    // Backpressure: dp_rdy toggles, req_val drops for two cycles
    do_reset();
    base = xfer_cnt;
    dp_auto = 1'b1; res_rdy = 1'b1;
    load(1, 8'd12, 8'd200, 8'd34, 8'd56, 4); exp_result(1, 8'd200);
    for (int c = 0; c < 14; c++) begin
      dp_rdy = (c % 2 == 0);
      en = {2'b00, !(c == 3 || c == 4), 1'b0};
      tick();
    end
    en = '0; dp_rdy = 1'b0;
    tick(); tick();
    chk("bp_xfer_count", 32'(xfer_cnt - base), 32'd4);
    wait_res(20);

    // Tag FIFO full with stalled results
    do_reset();
    base = xfer_cnt;
    load(0, 8'd3,  8'd8,  8'd1,  8'd2,  4);
    load(1, 8'd20, 8'd21, 8'd22, 8'd23, 4);
    load(2, 8'd30, 8'd31, 8'd32, 8'd33, 4);
    load(3, 8'd40, 8'd41, 8'd42, 8'd43, 4);
    load(0, 8'd70, 8'd71, 8'd72, 8'd73, 4);
    en = 4'b1111; dp_rdy = 1'b1;
    wait_xfers(base + 16, 40);
    man_val = 1'b1; man_data = 8'd8;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("full_req_rdy", 32'(req_rdy), 32'd0);
      chk("full_dp_val", 32'(dp_val), 32'd0);
      chk("full_res_val", 32'(res_val), 32'd1);
      chk("full_res_id", 32'(res_id), 32'd0);
      tick();
    end
    res_rdy = 1'b1;
    exp_result(0, 8'd8);
    @(negedge clk);
    chk("full_pop_req_rdy", 32'(req_rdy), 32'd0);
    tick();
    res_rdy = 1'b0; man_val = 1'b0;
    @(negedge clk);
    chk("full_regrant_idle", 32'(req_rdy), 32'd0);
    tick();
    @(negedge clk);
    chk("full_fifth_grant", 32'(req_rdy), 32'd1);
    wait_xfers(base + 20, 20);
    chk("full_no_err", 32'(err), 32'd0);
    chk("full_res_drained", 32'(exp_res.size()), 32'd0);

    // Reset mid-frame after 2 of 4 words, one tag outstanding
    do_reset();
    base = xfer_cnt;
    dp_auto = 1'b1; res_rdy = 1'b1;
    load(1, 8'h21, 8'h22, 8'h00, 8'h00, 2);
    en = 4'b0010; dp_rdy = 1'b1;
    wait_xfers(base + 2, 20);
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outs("midrst");
    tick();
    base = xfer_cnt;
    load(0, 8'd5, 8'd6, 8'd7, 8'd8, 4); exp_result(0, 8'd8);
    load(2, 8'd9, 8'd1, 8'd2, 8'd3, 4); exp_result(2, 8'd9);
    en = 4'b0101;
    wait_xfers(base + 8, 30);
    wait_res(20);
    @(negedge clk);
    chk("midrst_busy_end", 32'(busy), 32'd0);

    chk("dp_queue_empty", 32'(exp_dp.size()), 32'd0);
    chk("res_queue_empty", 32'(exp_res.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
